snn_grid_load_sequencer: RTL and testbench

//  Hardware load sequencer for the SNN core grid, generalised over core count, neuron count and word widths.

---
 rtl/snn_grid_load_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_snn_grid_load_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_grid_load_sequencer.sv
// Load sequencer for the SNN core grid: drains one word stream into parameter, instruction and packet writes.
// Defining SNN_SEQ_TIMEOUT_EN adds a 20-bit wait watchdog that parks the FSM in ERR and raises seq_err.
module snn_grid_load_sequencer #(
    parameter int NUM_CORES   = 5,
    parameter int NEURONS     = 256,
    parameter int PARAM_WORDS = 12,
    parameter int INST_W      = 2,
    parameter int PACKET_W    = 30,
    parameter int COUNT_W     = 12,
    parameter int NUM_PICTURE = 100,
    parameter int WARMUP      = 3,
    parameter int GSTATE_W    = 3,
    parameter int GDONE       = 7
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [31:0]         src_data,
    input  logic                next_core_en,
    input  logic [GSTATE_W-1:0] grid_state,
    input  logic                complete,
    output logic                param_winc,
    output logic [31:0]         parameter_in,
    output logic [2:0]          next_core,
    output logic                neuron_inst_winc,
    output logic [INST_W-1:0]   neuron_inst_wdata,
    output logic                packet_winc,
    output logic [PACKET_W-1:0] packet_wdata,
    output logic                spike_en,
    output logic                load_end,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  pic_idx,
    output logic                seq_err
);

    localparam int PARAM_TOTAL = NEURONS * PARAM_WORDS;
    localparam int WCNT_W      = $clog2(PARAM_TOTAL + 1);

    localparam logic [WCNT_W-1:0]   PARAM_LAST = WCNT_W'(PARAM_TOTAL - 1);
    localparam logic [WCNT_W-1:0]   INST_LAST  = WCNT_W'(NEURONS - 1);
    localparam logic [2:0]          LAST_CORE  = 3'(NUM_CORES - 1);
    localparam logic [COUNT_W-1:0]  LAST_PIC   = COUNT_W'(NUM_PICTURE - 1);
    localparam logic [COUNT_W-1:0]  WARM_PIC   = COUNT_W'(WARMUP);
    localparam logic [GSTATE_W-1:0] GDONE_V    = GSTATE_W'(GDONE);

    typedef enum logic [3:0] {
        S_IDLE, S_PARAM, S_WAIT_CORE, S_INST, S_HDR, S_PKT, S_WAIT_TICK, S_FINISH, S_DONE, S_ERR
    } state_t;

    state_t              state, state_next;
    logic [WCNT_W-1:0]   word_cnt;
    logic [COUNT_W-1:0]  pkt_cnt;
    logic                slot_busy;
    logic                next_core_en_q;
    logic                seen_busy;
    logic                hs, core_rise, tick_done, restart, in_frame;

    assign hs        = src_valid & src_ready;
    assign core_rise = next_core_en & ~next_core_en_q;
    assign tick_done = seen_busy && (grid_state == GDONE_V);
    assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign in_frame  = (state == S_HDR || state == S_PKT || state == S_WAIT_TICK);

`ifdef SNN_SEQ_TIMEOUT_EN
    logic [19:0] wd_cnt;
    logic        in_wait;

    assign in_wait = (state == S_WAIT_CORE || state == S_WAIT_TICK || state == S_FINISH);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                  wd_cnt <= '0;
        else if (state_next != state) wd_cnt <= '0;
        else if (in_wait)             wd_cnt <= wd_cnt + 20'd1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_PARAM;
            S_PARAM:     if (hs && word_cnt == PARAM_LAST) state_next = S_WAIT_CORE;
            S_WAIT_CORE: if (core_rise) state_next = (next_core == LAST_CORE) ? S_INST : S_PARAM;
            S_INST:      if (hs && word_cnt == INST_LAST) state_next = S_HDR;
            S_HDR:       if (hs) state_next = (src_data[COUNT_W-1:0] == '0) ? S_WAIT_TICK : S_PKT;
            S_PKT:       if (hs && pkt_cnt == COUNT_W'(1)) state_next = S_WAIT_TICK;
            S_WAIT_TICK: if (tick_done) state_next = (pic_idx == LAST_PIC) ? S_FINISH : S_HDR;
            S_FINISH:    if (complete) state_next = S_DONE;
            default:     state_next = S_IDLE;
        endcase
`ifdef SNN_SEQ_TIMEOUT_EN
        if (in_wait && state_next == state && wd_cnt == 20'hFFFFF) state_next = S_ERR;
`endif
    end

    always_comb begin
        src_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        seq_err   = 1'b0;
        case (state)
            S_PARAM, S_INST, S_HDR, S_PKT: begin
                src_ready = ~slot_busy;
                busy      = 1'b1;
            end
            S_WAIT_CORE, S_WAIT_TICK, S_FINISH: busy = 1'b1;
            S_DONE:  done = 1'b1;
`ifdef SNN_SEQ_TIMEOUT_EN
            S_ERR:   seq_err = 1'b1;
`endif
            default: ;
        endcase
    end

    // A handshake occupies the slot for one cycle; the strobe fires in that cycle with src_ready low.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot_busy         <= 1'b0;
            next_core_en_q    <= 1'b0;
            param_winc        <= 1'b0;
            neuron_inst_winc  <= 1'b0;
            packet_winc       <= 1'b0;
            parameter_in      <= '0;
            neuron_inst_wdata <= '0;
            packet_wdata      <= '0;
            word_cnt          <= '0;
            pkt_cnt           <= '0;
            next_core         <= '0;
            pic_idx           <= '0;
            spike_en          <= 1'b0;
            load_end          <= 1'b0;
            seen_busy         <= 1'b0;
        end else begin
            slot_busy        <= hs;
            next_core_en_q   <= next_core_en;
            param_winc       <= hs && state == S_PARAM;
            neuron_inst_winc <= hs && state == S_INST;
            packet_winc      <= hs && state == S_PKT;

            if (hs && state == S_PARAM) parameter_in      <= src_data;
            if (hs && state == S_INST)  neuron_inst_wdata <= src_data[INST_W-1:0];
            if (hs && state == S_PKT)   packet_wdata      <= src_data[PACKET_W-1:0];

            if (state_next != state) word_cnt <= '0;
            else if (hs)             word_cnt <= word_cnt + WCNT_W'(1);

            if (hs && state == S_HDR)      pkt_cnt <= src_data[COUNT_W-1:0];
            else if (hs && state == S_PKT) pkt_cnt <= pkt_cnt - COUNT_W'(1);

            if (restart) begin
                next_core <= '0;
                pic_idx   <= '0;
                spike_en  <= 1'b0;
                load_end  <= 1'b0;
                seen_busy <= 1'b0;
            end else begin
                if (state == S_WAIT_CORE && core_rise) next_core <= next_core + 3'd1;
                // The grid must be seen busy after the header before a GDONE level counts as this tick.
                if (state == S_WAIT_TICK && tick_done) begin
                    seen_busy <= 1'b0;
                    pic_idx   <= pic_idx + COUNT_W'(1);
                    if (pic_idx + COUNT_W'(1) >= WARM_PIC) spike_en <= 1'b1;
                    if (pic_idx == LAST_PIC) load_end <= 1'b1;
                end else if (in_frame && grid_state != GDONE_V) begin
                    seen_busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snn_grid_load_sequencer.sv
// Scoreboard bench for snn_grid_load_sequencer: the driver queues expected writes, a monitor pops them on strobes.
// Small grid (2 cores, 2 neurons, 3 words, 4 pictures, warm-up 1) with randomized data and valid gaps.
module tb_snn_grid_load_sequencer;

    localparam int NUM_CORES   = 2;
    localparam int NEURONS     = 2;
    localparam int PARAM_WORDS = 3;
    localparam int INST_W      = 2;
    localparam int PACKET_W    = 30;
    localparam int COUNT_W     = 12;
    localparam int NUM_PICTURE = 4;
    localparam int WARMUP      = 1;
    localparam int GSTATE_W    = 3;
    localparam int GDONE       = 7;
    localparam int PARAM_TOTAL = NEURONS * PARAM_WORDS;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic                start = 1'b0;
    logic                src_valid = 1'b0;
    logic                src_ready;
    logic [31:0]         src_data = '0;
    logic                next_core_en = 1'b0;
    logic [GSTATE_W-1:0] grid_state = 3'd7;
    logic                complete = 1'b0;
    logic                param_winc;
    logic [31:0]         parameter_in;
    logic [2:0]          next_core;
    logic                neuron_inst_winc;
    logic [INST_W-1:0]   neuron_inst_wdata;
    logic                packet_winc;
    logic [PACKET_W-1:0] packet_wdata;
    logic                spike_en;
    logic                load_end;
    logic                busy;
    logic                done;
    logic [COUNT_W-1:0]  pic_idx;
    logic                seq_err;

    snn_grid_load_sequencer #(
        .NUM_CORES(NUM_CORES), .NEURONS(NEURONS), .PARAM_WORDS(PARAM_WORDS), .INST_W(INST_W),
        .PACKET_W(PACKET_W), .COUNT_W(COUNT_W), .NUM_PICTURE(NUM_PICTURE), .WARMUP(WARMUP),
        .GSTATE_W(GSTATE_W), .GDONE(GDONE)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .src_valid(src_valid),
        .src_ready(src_ready), .src_data(src_data), .next_core_en(next_core_en),
        .grid_state(grid_state), .complete(complete), .param_winc(param_winc),
        .parameter_in(parameter_in), .next_core(next_core), .neuron_inst_winc(neuron_inst_winc),
        .neuron_inst_wdata(neuron_inst_wdata), .packet_winc(packet_winc),
        .packet_wdata(packet_wdata), .spike_en(spike_en), .load_end(load_end), .busy(busy),
        .done(done), .pic_idx(pic_idx), .seq_err(seq_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] tag;
    } exp_t;

    exp_t param_q[$];
    exp_t inst_q[$];
    exp_t pkt_q[$];

    int checks = 0;
    int errors = 0;
    int param_seen = 0;
    int inst_seen = 0;
    int pkt_seen = 0;
    logic prev_param = 1'b0, prev_inst = 1'b0, prev_pkt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Offers one word with random valid gaps until it is accepted or the cycle budget runs out.
    task automatic send_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        for (int cyc = 0; cyc < 64 && !ok; cyc++) begin
            @(negedge sys_clk);
            src_data  = w;
            src_valid = ($urandom_range(0, 2) != 0);
            #1;
            ok = src_valid && src_ready;
            @(posedge sys_clk);
        end
        #1 src_valid = 1'b0;
        if (!ok) check("send_word accepted within budget", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk) start = 1'b1;
        @(negedge sys_clk) start = 1'b0;
    endtask

    task automatic send_params(input int core, input int n, input bit poke_start);
        logic [31:0] w;
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (poke_start && i == 2) pulse_start();
            w = $urandom;
            send_word(w, ok);
            if (ok) param_q.push_back('{w, 32'(core)});
        end
    endtask

    task automatic send_insts();
        logic [31:0] w;
        bit ok;
        for (int i = 0; i < NEURONS; i++) begin
            w = $urandom;
            send_word(w, ok);
            if (ok) inst_q.push_back('{{30'd0, w[1:0]}, 32'd0});
        end
    endtask

    task automatic send_header(input int count);
        logic [31:0] w;
        bit ok;
        w = $urandom;
        w[COUNT_W-1:0] = COUNT_W'(count);
        send_word(w, ok);
    endtask

    task automatic send_packets(input int count, input int pic);
        logic [31:0] w;
        bit ok;
        for (int k = 0; k < count; k++) begin
            w = $urandom;
            send_word(w, ok);
            if (ok) pkt_q.push_back('{{2'b00, w[PACKET_W-1:0]}, 32'(pic)});
        end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst) begin
            if (param_winc) begin
                param_seen++;
                check("param strobe slot blocks src_ready", 32'(src_ready), 32'd0);
                check("param strobe single cycle", 32'(prev_param), 32'd0);
                if (param_q.size() == 0) check("param strobe without handshake", 32'd1, 32'd0);
                else begin
                    e = param_q.pop_front();
                    check("parameter_in", parameter_in, e.data);
                    check("next_core during param write", 32'(next_core), e.tag);
                end
            end
            if (neuron_inst_winc) begin
                inst_seen++;
                check("inst strobe single cycle", 32'(prev_inst), 32'd0);
                if (inst_q.size() == 0) check("inst strobe without handshake", 32'd1, 32'd0);
                else begin
                    e = inst_q.pop_front();
                    check("neuron_inst_wdata", 32'(neuron_inst_wdata), e.data);
                end
            end
            if (packet_winc) begin
                pkt_seen++;
                check("packet strobe slot blocks src_ready", 32'(src_ready), 32'd0);
                check("packet strobe single cycle", 32'(prev_pkt), 32'd0);
                if (pkt_q.size() == 0) check("packet strobe without handshake", 32'd1, 32'd0);
                else begin
                    e = pkt_q.pop_front();
                    check("packet_wdata", 32'(packet_wdata), e.data);
                    check("pic_idx during packet write", 32'(pic_idx), e.tag);
                end
            end
        end
        prev_param = param_winc;
        prev_inst  = neuron_inst_winc;
        prev_pkt   = packet_winc;
    end

    initial begin
        #2_000_000;
        check("global time limit", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int hdr_counts[NUM_PICTURE] = '{2, 0, 3, 1};
        wait_cyc(3);
        check("reset: all outputs zero", 32'(|{src_ready, param_winc, parameter_in, next_core,
              neuron_inst_winc, neuron_inst_wdata, packet_winc, packet_wdata, spike_en,
              load_end, busy, done, pic_idx, seq_err}), 32'd0);
        sys_rst = 1'b0;
        wait_cyc(2);
        check("idle busy", 32'(busy), 32'd0);
        check("idle src_ready", 32'(src_ready), 32'd0);

        // Run 1: core 0 parameters, then a deliberate wait before next_core_en rises.
        pulse_start();
        check("start enters PARAM", 32'({busy, src_ready}), 32'b11);
        send_params(0, PARAM_TOTAL, 1'b0);
        wait_cyc(4);
        check("core 0 param strobes", 32'(param_seen), 32'(PARAM_TOTAL));
        check("next_core held before rise", 32'(next_core), 32'd0);
        check("WAIT_CORE src_ready", 32'(src_ready), 32'd0);
        next_core_en = 1'b1;
        @(negedge sys_clk);
        check("next_core after rise", 32'(next_core), 32'd1);

        // Core 1 with next_core_en still high and a stray start that must be ignored.
        send_params(1, PARAM_TOTAL, 1'b1);
        wait_cyc(5);
        check("held next_core_en ignored", 32'(next_core), 32'd1);
        check("still in WAIT_CORE", 32'({busy, src_ready}), 32'b10);
        next_core_en = 1'b0;
        wait_cyc(2);
        next_core_en = 1'b1;
        @(negedge sys_clk);
        check("next_core reaches NUM_CORES", 32'(next_core), 32'(NUM_CORES));
        check("INST accepting", 32'(src_ready), 32'd1);
        next_core_en = 1'b0;
        send_insts();

        for (int p = 0; p < NUM_PICTURE; p++) begin
            bit early = (p % 2) == 1;
            if (early) grid_state = 3'($urandom_range(0, 6));
            send_header(hdr_counts[p]);
            send_packets(hdr_counts[p], p);
            if (!early) begin
                wait_cyc(4);
                check("no tick exit while grid idle", 32'(pic_idx), 32'(p));
                check("spike_en before exit", 32'(spike_en), 32'(p >= WARMUP));
                grid_state = 3'($urandom_range(0, 6));
                wait_cyc($urandom_range(1, 3));
            end
            grid_state = 3'd7;
            wait_cyc(3);
            check("pic_idx after tick", 32'(pic_idx), 32'(p + 1));
            check("spike_en after tick", 32'(spike_en), 32'(p + 1 >= WARMUP));
            check("load_end after tick", 32'(load_end), 32'(p == NUM_PICTURE - 1));
        end
        check("total packet strobes", 32'(pkt_seen), 32'd6);
        check("total inst strobes", 32'(inst_seen), 32'(NEURONS));
        wait_cyc(3);
        check("FINISH waits for complete", 32'({busy, done}), 32'b10);
        complete = 1'b1;
        @(negedge sys_clk);
        complete = 1'b0;
        wait_cyc(1);
        check("DONE state", 32'({busy, done}), 32'b01);
        check("load_end sticky", 32'(load_end), 32'd1);

        // Run 2: restart from DONE, then abort mid-packet with reset.
        pulse_start();
        check("restart clears run state", 32'({next_core, pic_idx, spike_en, load_end}), 32'd0);
        check("restart busy", 32'({busy, done}), 32'b10);
        send_params(0, PARAM_TOTAL, 1'b0);
        wait_cyc(2);
        next_core_en = 1'b1;
        wait_cyc(1);
        send_params(1, PARAM_TOTAL, 1'b0);
        wait_cyc(2);
        next_core_en = 1'b0;
        wait_cyc(2);
        next_core_en = 1'b1;
        wait_cyc(1);
        next_core_en = 1'b0;
        send_insts();
        send_header(3);
        send_packets(1, 0);
        wait_cyc(2);
        #2 sys_rst = 1'b1;
        #1;
        check("async reset clears outputs", 32'(|{src_ready, param_winc, parameter_in, next_core,
              neuron_inst_winc, neuron_inst_wdata, packet_winc, packet_wdata, spike_en,
              load_end, busy, done, pic_idx, seq_err}), 32'd0);
        param_q.delete();
        inst_q.delete();
        pkt_q.delete();
        wait_cyc(2);
        sys_rst = 1'b0;
        wait_cyc(1);
        pulse_start();
        check("post-reset start in PARAM", 32'({busy, src_ready, next_core}), 32'b11_000);
        send_params(0, 3, 1'b0);
        wait_cyc(3);
        check("param queue drained", 32'(param_q.size()), 32'd0);
        check("inst queue drained", 32'(inst_q.size()), 32'd0);
        check("packet queue drained", 32'(pkt_q.size()), 32'd0);
        check("seq_err tied low", 32'(seq_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
